// File: rtl/ysyx_25040111_csr_file.sv
// Machine-mode CSR file: two combinational read ports plus one handshaked update port
// that commits CSRW/CSRS writes and sequences the ECALL/MRET trap updates.
module ysyx_25040111_csr_file #(
    parameter logic [31:0] MVENDORID  = 32'h7973_7978,
    parameter logic [31:0] MARCHID    = 32'h017E_3D8F,
    parameter logic [31:0] ECALL_CODE = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rd_addr1,
    output logic [31:0] rd_data1,
    input  logic [11:0] rd_addr2,
    output logic [31:0] rd_data2,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        done,
    output logic        illegal_wr
);
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    localparam logic [1:0] OP_CSRW  = 2'b00;
    localparam logic [1:0] OP_CSRS  = 2'b01;
    localparam logic [1:0] OP_ECALL = 2'b10;
    localparam logic [1:0] OP_MRET  = 2'b11;

    typedef enum logic [1:0] {IDLE, TRAP, RESP} state_t;

    state_t      state_reg, state_next;
    logic        done_reg, done_next;
    logic        illegal_reg, illegal_next;
    logic        mie_reg, mpie_reg;
    logic [31:0] mtvec_reg, mepc_reg, mcause_reg;
    logic [63:0] mcycle_reg;

    logic [31:0] mstatus_val, cur_val, wr_val;
    logic        accept, is_write, addr_ok;
    logic        unused_pc;

    function automatic logic [31:0] csr_mux(
        input logic [11:0] addr,
        input logic [31:0] mstatus,
        input logic [31:0] mtvec,
        input logic [31:0] mepc,
        input logic [31:0] mcause,
        input logic [63:0] mcycle
    );
        logic [31:0] val;
        case (addr)
            ADDR_MSTATUS:   val = mstatus;
            ADDR_MTVEC:     val = mtvec;
            ADDR_MEPC:      val = mepc;
            ADDR_MCAUSE:    val = mcause;
            ADDR_MCYCLE:    val = mcycle[31:0];
            ADDR_MCYCLEH:   val = mcycle[63:32];
            ADDR_MVENDORID: val = MVENDORID;
            ADDR_MARCHID:   val = MARCHID;
            default:        val = 32'h0;
        endcase
        return val;
    endfunction

    // MPP is hardwired to machine mode; only MIE and MPIE hold state
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_reg, 3'b0, mie_reg, 3'b0};

    logic [11:0] rd_addr_arr [2];
    logic [31:0] rd_data_arr [2];
    assign rd_addr_arr[0] = rd_addr1;
    assign rd_addr_arr[1] = rd_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data_arr[gi] = csr_mux(rd_addr_arr[gi], mstatus_val, mtvec_reg,
                                             mepc_reg, mcause_reg, mcycle_reg);
        end
    endgenerate

    assign rd_data1 = rd_data_arr[0];
    assign rd_data2 = rd_data_arr[1];

    assign req_ready  = (state_reg == IDLE);
    assign accept     = req_valid & req_ready;
    assign is_write   = ~req_op[1];
    assign done       = done_reg;
    assign illegal_wr = illegal_reg;
    assign unused_pc  = ^req_pc[1:0];

    assign cur_val = csr_mux(req_addr, mstatus_val, mtvec_reg, mepc_reg, mcause_reg, mcycle_reg);
    assign wr_val  = (req_op == OP_CSRS) ? (cur_val | req_wdata) : req_wdata;

    always_comb begin
        addr_ok = 1'b0;
        case (req_addr)
            ADDR_MSTATUS, ADDR_MTVEC, ADDR_MEPC, ADDR_MCAUSE,
            ADDR_MCYCLE, ADDR_MCYCLEH: addr_ok = 1'b1;
            default:                   addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_ECALL) begin
                        state_next = TRAP;
                    end else begin
                        state_next   = RESP;
                        done_next    = 1'b1;
                        illegal_next = is_write & ~addr_ok;
                    end
                end
            end
            TRAP: begin
                state_next = RESP;
                done_next  = 1'b1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            done_reg    <= done_next;
            illegal_reg <= illegal_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_reg    <= 1'b0;
            mpie_reg   <= 1'b0;
            mtvec_reg  <= 32'h0;
            mepc_reg   <= 32'h0;
            mcause_reg <= 32'h0;
            mcycle_reg <= 64'h0;
        end else begin
            mcycle_reg <= mcycle_reg + 64'd1;
            // A write to either mcycle half replaces the whole increment for this edge
            if (accept && is_write) begin
                case (req_addr)
                    ADDR_MSTATUS: begin
                        mie_reg  <= wr_val[3];
                        mpie_reg <= wr_val[7];
                    end
                    ADDR_MTVEC:   mtvec_reg  <= {wr_val[31:2], 2'b00};
                    ADDR_MEPC:    mepc_reg   <= {wr_val[31:2], 2'b00};
                    ADDR_MCAUSE:  mcause_reg <= wr_val;
                    ADDR_MCYCLE:  mcycle_reg <= {mcycle_reg[63:32], wr_val};
                    ADDR_MCYCLEH: mcycle_reg <= {wr_val, mcycle_reg[31:0]};
                    default: ;
                endcase
            end
            if (accept && req_op == OP_ECALL) begin
                mepc_reg <= {req_pc[31:2], 2'b00};
            end
            if (state_reg == TRAP) begin
                mcause_reg <= ECALL_CODE;
                mpie_reg   <= mie_reg;
                mie_reg    <= 1'b0;
            end
            if (accept && req_op == OP_MRET) begin
                mie_reg  <= mpie_reg;
                mpie_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_csr_file.sv
// Table-driven bench for the CSR file: each request's expectation is queued when driven
// and checked when its done pulse appears; reset, mcycle wrap and mid-trap reset by hand.
module tb_ysyx_25040111_csr_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata, req_pc;
    logic        done, illegal_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040111_csr_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .done(done), .illegal_wr(illegal_wr)
    );

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [11:0] chk1;
        logic [31:0] exp1;
        logic [11:0] chk2;
        logic [31:0] exp2;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at a negedge, DUT idle again.
    task automatic do_req(input int idx, input vec_t v);
        vec_t e;
        int   lat;
        bit   seen;
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_pc    = v.pc;
        rd_addr1  = v.chk1;
        rd_addr2  = v.chk2;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        // keep valid high with junk while busy: the DUT must not take it
        req_op    = 2'($urandom);
        req_addr  = 12'($urandom);
        req_wdata = $urandom;
        req_pc    = $urandom;
        seen = 0;
        lat  = 0;
        for (int c = 1; c <= 5 && !seen; c++) begin
            @(negedge clk);
            check("ready_busy", {31'b0, req_ready}, 32'd0);
            if (done) begin
                seen = 1;
                lat  = c;
            end
        end
        req_valid = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("latency", lat, e.exp_lat);
            check("illegal_wr", {31'b0, illegal_wr}, {31'b0, e.exp_ill});
            check("rd_data1", rd_data1, e.exp1);
            check("rd_data2", rd_data2, e.exp2);
        end
        @(posedge clk);
        @(negedge clk);
        check("done_idle", {31'b0, done}, 32'd0);
        check("ill_idle", {31'b0, illegal_wr}, 32'd0);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        $display("txn %0d op=%0d addr=%h lat=%0d rd1=%h rd2=%h", idx, v.op, v.addr, lat,
                 rd_data1, rd_data2);
    endtask

    initial begin
        //          op     addr     wdata          pc             chk1     exp1           chk2     exp2           ill   lat
        vecs[0]  = '{2'd0, 12'h305, 32'h8000_0103, 32'h0,         12'h305, 32'h8000_0100, 12'h300, 32'h0000_1800, 1'b0, 1};
        vecs[1]  = '{2'd1, 12'h300, 32'h0000_0008, 32'h0,         12'h300, 32'h0000_1808, 12'h305, 32'h8000_0100, 1'b0, 1};
        vecs[2]  = '{2'd2, 12'h000, 32'h0,         32'h8000_0047, 12'h341, 32'h8000_0044, 12'h342, 32'd11,        1'b0, 2};
        vecs[3]  = '{2'd1, 12'h342, 32'h0,         32'h0,         12'h300, 32'h0000_1880, 12'h342, 32'd11,        1'b0, 1};
        vecs[4]  = '{2'd3, 12'h000, 32'h0,         32'h0,         12'h300, 32'h0000_1888, 12'h341, 32'h8000_0044, 1'b0, 1};
        vecs[5]  = '{2'd0, 12'hF11, 32'h0,         32'h0,         12'hF11, 32'h7973_7978, 12'hF12, 32'h017E_3D8F, 1'b1, 1};
        vecs[6]  = '{2'd0, 12'h123, 32'hFFFF_FFFF, 32'h0,         12'h123, 32'h0,         12'h305, 32'h8000_0100, 1'b1, 1};
        vecs[7]  = '{2'd0, 12'h300, 32'h0000_0080, 32'h0,         12'h300, 32'h0000_1880, 12'h342, 32'd11,        1'b0, 1};
        vecs[8]  = '{2'd0, 12'h341, 32'h1234_5677, 32'h0,         12'h341, 32'h1234_5674, 12'h300, 32'h0000_1880, 1'b0, 1};
        vecs[9]  = '{2'd1, 12'h305, 32'h0000_0003, 32'h0,         12'h305, 32'h8000_0100, 12'h341, 32'h1234_5674, 1'b0, 1};
        vecs[10] = '{2'd3, 12'h000, 32'h0,         32'h0,         12'h300, 32'h0000_1888, 12'h305, 32'h8000_0100, 1'b0, 1};
        vecs[11] = '{2'd0, 12'h342, 32'hFFFF_FFFF, 32'h0,         12'h342, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0, 1};
        vecs[12] = '{2'd0, 12'h300, 32'hFFFF_FFFF, 32'h0,         12'h300, 32'h0000_1888, 12'h342, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[13] = '{2'd0, 12'hB80, 32'hFFFF_FFFF, 32'h0,         12'hB80, 32'hFFFF_FFFF, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[14] = '{2'd0, 12'hB00, 32'hFFFF_FFFE, 32'h0,         12'hB00, 32'hFFFF_FFFE, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'd0; req_addr = 12'h0; req_wdata = 32'h0; req_pc = 32'h0;
        rd_addr1 = 12'h300; rd_addr2 = 12'h305;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mstatus", rd_data1, 32'h0000_1800);
        check("rst_mtvec", rd_data2, 32'h0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ill", {31'b0, illegal_wr}, 32'd0);
        rd_addr2 = 12'hB00;
        #1;
        check("rst_mcycle", rd_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mcycle_first", rd_data2, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 15; i++) do_req(i, vecs[i]);

        rd_addr1 = 12'hB00;
        rd_addr2 = 12'hB80;
        #1;
        check("mcycle_lo_max", rd_data1, 32'hFFFF_FFFF);
        check("mcycle_hi_max", rd_data2, 32'hFFFF_FFFF);
        @(negedge clk);
        check("mcycle_lo_wrap", rd_data1, 32'h0);
        check("mcycle_hi_wrap", rd_data2, 32'h0);
        $display("txn mcycle wrap lo=%h hi=%h", rd_data1, rd_data2);

        // reset while the ECALL sits in TRAP: the mepc update must be discarded
        rd_addr1 = 12'h341;
        rd_addr2 = 12'h300;
        req_valid = 1'b1; req_op = 2'd2; req_addr = 12'h0; req_pc = 32'h8000_0100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("trap_mepc", rd_data1, 32'h8000_0100);
        @(negedge clk);
        check("trap_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_mepc", rd_data1, 32'h0);
        check("arst_mstatus", rd_data2, 32'h0000_1800);
        check("arst_ready", {31'b0, req_ready}, 32'd1);
        check("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("arst_no_done", {31'b0, done}, 32'd0);
            check("arst_ready_hold", {31'b0, req_ready}, 32'd1);
        end
        check("arst_mepc_hold", rd_data1, 32'h0);
        $display("txn reset-in-trap mepc=%h mstatus=%h", rd_data1, rd_data2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
